// File: rtl/regwrite_arbiter.sv
// regwrite_arbiter
//   Arbitrates two writeback requesters (A = ALU, B = memory) onto a single
//   register-file write port. At most one grant per cycle, round-robin between
//   the two when both are valid. The winning write is registered and appears on
//   RegWrite/WriteReg/WriteData one cycle later. Writes to register 0 are
//   accepted but never assert RegWrite. Hazard flags tell the read stage that a
//   register it reads has a write pending, either in flight or still requested.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   hold                  suppresses all grants this cycle
//   a_valid/a_ready       requester A handshake
//   a_reg/a_data          requester A destination index and data
//   b_valid/b_ready       requester B handshake
//   b_reg/b_data          requester B destination index and data
//   RegWrite              registered write enable
//   WriteReg/WriteData    registered write index and data
//   ReadReg1/ReadReg2     indices being read from the register file
//   hazard1/hazard2       read of ReadReg1/ReadReg2 would return stale data
module regwrite_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_reg,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_reg,
  input  logic [DATA_W-1:0] b_data,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] WriteReg,
  output logic [DATA_W-1:0] WriteData,
  input  logic [ADDR_W-1:0] ReadReg1,
  input  logic [ADDR_W-1:0] ReadReg2,
  output logic              hazard1,
  output logic              hazard2
);

  // Priority pointer: 0 favours A, 1 favours B when both are valid.
  logic prio;
  logic grant_a;
  logic grant_b;
  logic both_valid;
  logic open_cycle;

  assign both_valid = a_valid & b_valid;
  assign open_cycle = ~reset & ~hold;

  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (open_cycle) begin
      if (both_valid) begin
        grant_a = ~prio;
        grant_b = prio;
      end else begin
        grant_a = a_valid;
        grant_b = b_valid;
      end
    end
  end

  assign a_ready = grant_a;
  assign b_ready = grant_b;

  // Pointer moves to the loser only after a contested grant; hold leaves it alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      prio <= 1'b0;
    end else if (both_valid && (grant_a || grant_b)) begin
      prio <= grant_a;
    end
  end

  // Output register. Index/data only update on a real (non-zero) write so a
  // register-0 transfer or an idle cycle leaves the last write visible.
  always_ff @(posedge clk) begin
    if (reset) begin
      RegWrite  <= 1'b0;
      WriteReg  <= '0;
      WriteData <= '0;
    end else if (grant_a && (a_reg != '0)) begin
      RegWrite  <= 1'b1;
      WriteReg  <= a_reg;
      WriteData <= a_data;
    end else if (grant_b && (b_reg != '0)) begin
      RegWrite  <= 1'b1;
      WriteReg  <= b_reg;
      WriteData <= b_data;
    end else begin
      RegWrite  <= 1'b0;
    end
  end

  // A read is stale if the register is being written next edge (RegWrite) or
  // is still owed a write by either requester, granted or not.
  always_comb begin
    hazard1 = (ReadReg1 != '0) &&
              ((RegWrite && (WriteReg == ReadReg1)) ||
               (a_valid && (a_reg == ReadReg1)) ||
               (b_valid && (b_reg == ReadReg1)));
    hazard2 = (ReadReg2 != '0) &&
              ((RegWrite && (WriteReg == ReadReg2)) ||
               (a_valid && (a_reg == ReadReg2)) ||
               (b_valid && (b_reg == ReadReg2)));
  end

endmodule

// File: tb/tb_regwrite_arbiter.sv
module tb_regwrite_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        hold;
  logic        a_valid;
  logic        a_ready;
  logic [4:0]  a_reg;
  logic [31:0] a_data;
  logic        b_valid;
  logic        b_ready;
  logic [4:0]  b_reg;
  logic [31:0] b_data;
  logic        RegWrite;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData;
  logic [4:0]  ReadReg1;
  logic [4:0]  ReadReg2;
  logic        hazard1;
  logic        hazard2;

  int checks = 0;
  int errors = 0;

  regwrite_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .reset(reset), .hold(hold),
    .a_valid(a_valid), .a_ready(a_ready), .a_reg(a_reg), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_reg(b_reg), .b_data(b_data),
    .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
    .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
    .hazard1(hazard1), .hazard2(hazard2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; hold = 1'b0;
    a_valid = 1'b1; a_reg = 5'd1; a_data = 32'h1;
    b_valid = 1'b0; b_reg = 5'd0; b_data = 32'h0;
    ReadReg1 = 5'd0; ReadReg2 = 5'd0;
    #1;
    chk("rst_a_ready", {31'b0, a_ready}, 32'd0);
    tick();
    tick();
    chk("rst_regwrite", {31'b0, RegWrite}, 32'd0);
    chk("rst_writereg", {27'b0, WriteReg}, 32'd0);
    chk("rst_writedata", WriteData, 32'd0);

    // single A write
    reset = 1'b0; a_valid = 1'b1; a_reg = 5'd5; a_data = 32'h1234;
    #1;
    chk("single_a_ready", {31'b0, a_ready}, 32'd1);
    chk("single_b_ready", {31'b0, b_ready}, 32'd0);
    tick();
    a_valid = 1'b0;
    chk("single_regwrite", {31'b0, RegWrite}, 32'd1);
    chk("single_writereg", {27'b0, WriteReg}, 32'd5);
    chk("single_writedata", WriteData, 32'h1234);
    tick();
    chk("single_drain", {31'b0, RegWrite}, 32'd0);
    chk("single_hold_reg", {27'b0, WriteReg}, 32'd5);

    // contested: A first, then B alone
    a_valid = 1'b1; a_reg = 5'd3; a_data = 32'h33;
    b_valid = 1'b1; b_reg = 5'd4; b_data = 32'h44;
    #1;
    chk("both_a_ready", {31'b0, a_ready}, 32'd1);
    chk("both_b_ready", {31'b0, b_ready}, 32'd0);
    tick();
    a_valid = 1'b0;
    chk("both_wr3", {27'b0, WriteReg}, 32'd3);
    chk("both_rw3", {31'b0, RegWrite}, 32'd1);
    chk("b_alone_ready", {31'b0, b_ready}, 32'd1);
    tick();
    b_valid = 1'b0;
    chk("both_wr4", {27'b0, WriteReg}, 32'd4);
    chk("both_wd4", WriteData, 32'h44);
    chk("both_rw4", {31'b0, RegWrite}, 32'd1);

    // round robin: reset pointer, then 4 contested cycles
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a_valid = 1'b1; a_reg = 5'(10 + i); a_data = 32'(32'hA0 + i);
      b_valid = 1'b1; b_reg = 5'(20 + i); b_data = 32'(32'hB0 + i);
      #1;
      chk($sformatf("rr_a_ready%0d", i), {31'b0, a_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("rr_b_ready%0d", i), {31'b0, b_ready}, (i % 2 == 1) ? 32'd1 : 32'd0);
      tick();
      chk($sformatf("rr_wreg%0d", i), {27'b0, WriteReg}, (i % 2 == 0) ? 32'(10 + i) : 32'(20 + i));
      chk($sformatf("rr_wdata%0d", i), WriteData, (i % 2 == 0) ? 32'(32'hA0 + i) : 32'(32'hB0 + i));
    end
    // pointer back at A
    #1;
    chk("rr_ptr_end", {31'b0, a_ready}, 32'd1);
    a_valid = 1'b0; b_valid = 1'b0;
    // in-flight write to 23 is a hazard
    ReadReg1 = 5'd23;
    #1;
    chk("haz_inflight", {31'b0, hazard1}, 32'd1);

    // register-0 write from B
    b_valid = 1'b1; b_reg = 5'd0; b_data = 32'hFFFF; ReadReg1 = 5'd0;
    #1;
    chk("r0_b_ready", {31'b0, b_ready}, 32'd1);
    chk("r0_hazard1", {31'b0, hazard1}, 32'd0);
    tick();
    b_valid = 1'b0;
    chk("r0_regwrite", {31'b0, RegWrite}, 32'd0);
    chk("r0_wreg_hold", {27'b0, WriteReg}, 32'd23);
    chk("r0_wdata_hold", WriteData, 32'hB3);

    // pending-request hazard from B
    b_valid = 1'b1; b_reg = 5'd8; ReadReg1 = 5'd8; hold = 1'b1;
    #1;
    chk("haz_b_pending", {31'b0, hazard1}, 32'd1);
    b_valid = 1'b0; hold = 1'b0; ReadReg1 = 5'd0;

    // hold then release
    a_valid = 1'b1; a_reg = 5'd7; a_data = 32'h77; hold = 1'b1; ReadReg2 = 5'd7;
    #1;
    chk("hold_a_ready", {31'b0, a_ready}, 32'd0);
    chk("hold_hazard2", {31'b0, hazard2}, 32'd1);
    tick();
    chk("hold_regwrite", {31'b0, RegWrite}, 32'd0);
    hold = 1'b0;
    #1;
    chk("release_a_ready", {31'b0, a_ready}, 32'd1);
    tick();
    a_valid = 1'b0;
    #1;
    chk("release_rw", {31'b0, RegWrite}, 32'd1);
    chk("release_wreg", {27'b0, WriteReg}, 32'd7);
    chk("release_haz2", {31'b0, hazard2}, 32'd1);
    tick();
    chk("release_drain", {31'b0, RegWrite}, 32'd0);
    chk("release_haz2_clr", {31'b0, hazard2}, 32'd0);
    ReadReg2 = 5'd0;

    // hold with both valid must not move the pointer (still A)
    a_valid = 1'b1; a_reg = 5'd1; a_data = 32'h11;
    b_valid = 1'b1; b_reg = 5'd2; b_data = 32'h22; hold = 1'b1;
    tick();
    tick();
    hold = 1'b0;
    #1;
    chk("hold_ptr_a", {31'b0, a_ready}, 32'd1);
    chk("hold_ptr_b", {31'b0, b_ready}, 32'd0);
    a_valid = 1'b0; b_valid = 1'b0;
    #1;

    // same index from both: A then B, B's data lands last
    a_valid = 1'b1; a_reg = 5'd6; a_data = 32'h1;
    b_valid = 1'b1; b_reg = 5'd6; b_data = 32'h2;
    tick();
    a_valid = 1'b0;
    chk("same_first", WriteData, 32'h1);
    tick();
    b_valid = 1'b0;
    chk("same_last", WriteData, 32'h2);
    chk("same_last_reg", {27'b0, WriteReg}, 32'd6);
    tick();

    // write to 9 discarded by reset
    a_valid = 1'b1; a_reg = 5'd9; a_data = 32'h99;
    tick();
    a_valid = 1'b0; reset = 1'b1;
    #1;
    chk("pre_rst_rw", {31'b0, RegWrite}, 32'd1);
    chk("rst_ready_zero", {31'b0, a_ready | b_ready}, 32'd0);
    a_valid = 1'b1;
    #1;
    chk("rst_ready_valid", {31'b0, a_ready}, 32'd0);
    a_valid = 1'b0;
    tick();
    chk("post_rst_rw", {31'b0, RegWrite}, 32'd0);
    chk("post_rst_wreg", {27'b0, WriteReg}, 32'd0);
    chk("post_rst_wdata", WriteData, 32'd0);
    reset = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regwrite_arbiter.md
REGWRITE_ARBITER -- requirements
Module: regwrite_arbiter

Interface
REQ-001 Parameter: DATA_W, 32, write-data width.
REQ-002 Parameter: ADDR_W, 5, register-index width (32 registers).
REQ-003 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  in  1  synchronous, active-high reset.
REQ-005 Port: hold  in  1  when 1, no grant is issued this cycle.
REQ-006 Port: a_valid / a_ready  in / out  1 / 1  requester A (ALU writeback) handshake.
REQ-007 Port: a_reg / a_data  in  ADDR_W / DATA_W  requester A destination index and data.
REQ-008 Port: b_valid / b_ready  in / out  1 / 1  requester B (memory writeback) handshake.
REQ-009 Port: b_reg / b_data  in  ADDR_W / DATA_W  requester B destination index and data.
REQ-010 Port: RegWrite  out  1  registered write enable to register file.
REQ-011 Port: WriteReg / WriteData  out  ADDR_W / DATA_W  registered write index and data.
REQ-012 Port: ReadReg1, ReadReg2  in  ADDR_W  indices currently being read from the register file.
REQ-013 Port: hazard1, hazard2  out  1  read of ReadReg1 / ReadReg2 would return stale data.

Function
REQ-014 The block SHALL grant at most one requester per cycle; a transfer occurs when x_valid and x_ready are both 1.
REQ-015 x_ready SHALL be combinational: 1 only for the granted requester; both 0 when hold=1 or reset=1.
REQ-016 One valid requester, hold=0 -> that requester SHALL be granted regardless of priority.
REQ-017 Both valid, hold=0 -> the requester selected by the 1-bit priority pointer SHALL be granted (0=A, 1=B).
REQ-018 The priority pointer SHALL flip to the non-granted requester only in cycles where both were valid and a grant was issued; otherwise it holds.
REQ-019 A transfer in cycle N SHALL drive RegWrite=1, WriteReg=x_reg, WriteData=x_data in cycle N+1 (one-cycle latency), except REQ-020.
REQ-020 A transfer with x_reg=0 SHALL be accepted (ready=1) but SHALL produce RegWrite=0 in cycle N+1; WriteReg/WriteData hold their previous values.
REQ-021 In cycles with no transfer, RegWrite SHALL be 0 next cycle and WriteReg/WriteData SHALL hold.
REQ-022 Requesters SHALL keep x_valid, x_reg, x_data stable until transfer; the block does not buffer ungranted requests.
REQ-023 hazardK SHALL be 1 iff ReadRegK != 0 and any of: (RegWrite=1 and WriteReg=ReadRegK); (a_valid=1 and a_reg=ReadRegK); (b_valid=1 and b_reg=ReadRegK).
REQ-024 hazard1/hazard2 SHALL be combinational from current inputs and the output register; a request to reg 0 never raises a hazard.
REQ-025 Both requesters targeting the same index in one cycle: arbitrated per REQ-017; the loser's write commits in a later cycle, so the later grant wins in the register file.
REQ-026 hold=1 SHALL not alter the priority pointer; the output register still drains (RegWrite=0 the following cycle).

Reset
REQ-027 While reset=1 at a rising edge: RegWrite<=0, WriteReg<=0, WriteData<=0, priority pointer<=0 (A).
REQ-028 A write registered in the cycle before reset SHALL be discarded: RegWrite=0 in the cycle after the reset edge.
REQ-029 a_ready=b_ready=0 in any cycle where reset=1; first grant possible in the first cycle with reset=0.

Verification
REQ-030 Reset, then a_valid=1, a_reg=5, a_data=0x1234 for one cycle -> a_ready=1 same cycle; next cycle RegWrite=1, WriteReg=5, WriteData=0x1234; following cycle RegWrite=0.
REQ-031 Both valid continuously (A: reg 3, B: reg 4), each dropping valid after its transfer -> A granted first (pointer=0), B next cycle; RegWrite pulses for reg 3 then reg 4 on consecutive cycles.
REQ-032 Both valid for 4 cycles with always-new requests -> grants alternate A,B,A,B; pointer ends at 0.
REQ-033 b_valid=1, b_reg=0, b_data=0xFFFF -> b_ready=1; RegWrite stays 0; ReadReg1=0 -> hazard1=0.
REQ-034 a_valid=1, a_reg=7, hold=1, ReadReg2=7 -> a_ready=0, hazard2=1; release hold -> transfer; hazard2 stays 1 through RegWrite=1 cycle, then 0.
REQ-035 Transfer to reg 9 in cycle N, reset=1 at edge N+1 -> RegWrite=0, WriteReg=0, WriteData=0 after that edge; no write to reg 9.
